// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider producing quotient and remainder,
// signed or unsigned per operation, one quotient bit per clock.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             exception
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sgn_reg;
  logic             dvd_neg_reg;
  logic             dvs_neg_reg;
  logic [WIDTH-1:0] dvd_reg;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_step;

  // Magnitudes are held as unsigned WIDTH-bit values, so the most-negative
  // operand maps cleanly onto 2^(WIDTH-1).
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // When the trial value is at least the divisor, the difference is below
  // the divisor and therefore fits in WIDTH bits.
  assign trial    = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff     = trial[WIDTH-1:0] - dvs_reg;
  assign q_bit    = (trial >= {1'b0, dvs_reg});
  assign rem_next = q_bit ? diff : trial[WIDTH-1:0];
  assign quo_next = {dvd_reg[WIDTH-2:0], q_bit};

  assign q_fix     = (sgn_reg & (dvd_neg_reg ^ dvs_neg_reg)) ? -quo_next : quo_next;
  assign r_fix     = (sgn_reg & dvd_neg_reg) ? -rem_next : rem_next;
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sgn_reg     <= 1'b0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      exception   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          ready <= 1'b0;
          if (start) begin
            sgn_reg     <= is_signed;
            dvd_neg_reg <= dvd_neg;
            dvs_neg_reg <= dvs_neg;
            dvd_reg     <= dvd_mag;
            dvs_reg     <= dvs_mag;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            exception   <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor completes immediately with the raw dividend.
              state_reg <= DONE;
              quotient  <= '0;
              remainder <= dividend;
              exception <= 1'b1;
              ready     <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
            end
          end else if (state_reg == DONE) begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          rem_reg <= rem_next;
          dvd_reg <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            ready     <= 1'b1;
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
